ps2_scancode_decoder: RTL and testbench

//  Consumes raw PS/2 set-2 bytes from the ps2_keyboard FIFO and produces one key event per

---
 rtl/ps2_codes_pkg.sv | 22 ++
 rtl/scancode_to_ascii.sv | 65 ++++++
 rtl/ps2_scancode_decoder.sv | 183 ++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_codes_pkg.sv
// rtl/ps2_codes_pkg.sv - PS/2 set-2 scancode constants and decoder state encoding
package ps2_codes_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_DEC  = 2'd2
    } dec_state_e;

    // Keyboard housekeeping bytes (BAT, echo, ack, error) that carry no key.
    function automatic logic is_dropped(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// rtl/scancode_to_ascii.sv - combinational set-2 scancode to ASCII map
module scancode_to_ascii (
    input  logic [7:0] code_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o
);

    // Letters, digits, space, enter and basic punctuation; anything else maps to 0.
    always_comb begin
        ascii_o = 8'h00;
        case (code_i)
            8'h1C: ascii_o = shift_i ? 8'h41 : 8'h61;
            8'h32: ascii_o = shift_i ? 8'h42 : 8'h62;
            8'h21: ascii_o = shift_i ? 8'h43 : 8'h63;
            8'h23: ascii_o = shift_i ? 8'h44 : 8'h64;
            8'h24: ascii_o = shift_i ? 8'h45 : 8'h65;
            8'h2B: ascii_o = shift_i ? 8'h46 : 8'h66;
            8'h34: ascii_o = shift_i ? 8'h47 : 8'h67;
            8'h33: ascii_o = shift_i ? 8'h48 : 8'h68;
            8'h43: ascii_o = shift_i ? 8'h49 : 8'h69;
            8'h3B: ascii_o = shift_i ? 8'h4A : 8'h6A;
            8'h42: ascii_o = shift_i ? 8'h4B : 8'h6B;
            8'h4B: ascii_o = shift_i ? 8'h4C : 8'h6C;
            8'h3A: ascii_o = shift_i ? 8'h4D : 8'h6D;
            8'h31: ascii_o = shift_i ? 8'h4E : 8'h6E;
            8'h44: ascii_o = shift_i ? 8'h4F : 8'h6F;
            8'h4D: ascii_o = shift_i ? 8'h50 : 8'h70;
            8'h15: ascii_o = shift_i ? 8'h51 : 8'h71;
            8'h2D: ascii_o = shift_i ? 8'h52 : 8'h72;
            8'h1B: ascii_o = shift_i ? 8'h53 : 8'h73;
            8'h2C: ascii_o = shift_i ? 8'h54 : 8'h74;
            8'h3C: ascii_o = shift_i ? 8'h55 : 8'h75;
            8'h2A: ascii_o = shift_i ? 8'h56 : 8'h76;
            8'h1D: ascii_o = shift_i ? 8'h57 : 8'h77;
            8'h22: ascii_o = shift_i ? 8'h58 : 8'h78;
            8'h35: ascii_o = shift_i ? 8'h59 : 8'h79;
            8'h1A: ascii_o = shift_i ? 8'h5A : 8'h7A;
            8'h16: ascii_o = shift_i ? 8'h21 : 8'h31;
            8'h1E: ascii_o = shift_i ? 8'h40 : 8'h32;
            8'h26: ascii_o = shift_i ? 8'h23 : 8'h33;
            8'h25: ascii_o = shift_i ? 8'h24 : 8'h34;
            8'h2E: ascii_o = shift_i ? 8'h25 : 8'h35;
            8'h36: ascii_o = shift_i ? 8'h5E : 8'h36;
            8'h3D: ascii_o = shift_i ? 8'h26 : 8'h37;
            8'h3E: ascii_o = shift_i ? 8'h2A : 8'h38;
            8'h46: ascii_o = shift_i ? 8'h28 : 8'h39;
            8'h45: ascii_o = shift_i ? 8'h29 : 8'h30;
            8'h4E: ascii_o = shift_i ? 8'h5F : 8'h2D;
            8'h55: ascii_o = shift_i ? 8'h2B : 8'h3D;
            8'h54: ascii_o = shift_i ? 8'h7B : 8'h5B;
            8'h5B: ascii_o = shift_i ? 8'h7D : 8'h5D;
            8'h4C: ascii_o = shift_i ? 8'h3A : 8'h3B;
            8'h52: ascii_o = shift_i ? 8'h22 : 8'h27;
            8'h41: ascii_o = shift_i ? 8'h3C : 8'h2C;
            8'h49: ascii_o = shift_i ? 8'h3E : 8'h2E;
            8'h4A: ascii_o = shift_i ? 8'h3F : 8'h2F;
            8'h0E: ascii_o = shift_i ? 8'h7E : 8'h60;
            8'h5D: ascii_o = shift_i ? 8'h7C : 8'h5C;
            8'h29: ascii_o = 8'h20;
            8'h5A: ascii_o = 8'h0D;
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 set-2 byte stream to key event decoder
module ps2_scancode_decoder
    import ps2_codes_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_ovf,
    output logic             nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic [7:0]       evt_ascii,
    output logic             shift_flag,
    output logic             ctrl_flag,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky
);

    dec_state_e       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             ext_p_q, ext_p_d, brk_p_q, brk_p_d;
    logic             lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d;
    logic             held_valid_q, held_valid_d;
    logic [8:0]       held_code_q, held_code_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             ovf_q, ovf_d;
    logic             evt_valid_q, evt_valid_d;
    logic [7:0]       evt_code_q, evt_code_d, evt_ascii_q, evt_ascii_d;
    logic             evt_ext_q, evt_ext_d, evt_break_q, evt_break_d;
    logic             evt_repeat_q, evt_repeat_d;

    logic [7:0]       ascii_w;
    logic             held_match;

    // Shift for the key being decoded; modifiers never emit events, so the
    // current flag already reflects any modifier byte that preceded it.
    scancode_to_ascii u_ascii (
        .code_i  (byte_q),
        .shift_i (lshift_q | rshift_q),
        .ascii_o (ascii_w)
    );

    assign held_match = held_valid_q && (held_code_q == {ext_p_q, byte_q});

    // Next-state: fetch FSM, prefix tracking, modifier flags and event generation.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_n_d = 1'b1;
        ext_p_d      = ext_p_q;
        brk_p_d      = brk_p_q;
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        ctrl_d       = ctrl_q;
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        press_cnt_d  = press_cnt_q;
        ovf_d        = ovf_q | ps2_ovf;
        evt_valid_d  = evt_valid_q && !evt_ready;
        evt_code_d   = evt_code_q;
        evt_ext_d    = evt_ext_q;
        evt_break_d  = evt_break_q;
        evt_repeat_d = evt_repeat_q;
        evt_ascii_d  = evt_ascii_q;

        case (state_q)
            ST_IDLE: begin
                if (ps2_ready && (!evt_valid_q || evt_ready)) begin
                    byte_d       = ps2_data;
                    nextdata_n_d = 1'b0;
                    state_d      = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_DEC;
            end
            ST_DEC: begin
                state_d = ST_IDLE;
                if (byte_q == SC_E0) begin
                    ext_p_d = 1'b1;
                end else if (byte_q == SC_F0) begin
                    brk_p_d = 1'b1;
                end else if (!ext_p_q && !brk_p_q && is_dropped(byte_q)) begin
                    ext_p_d = 1'b0;
                end else begin
                    ext_p_d = 1'b0;
                    brk_p_d = 1'b0;
                    if (byte_q == SC_LSHIFT) begin
                        lshift_d = !brk_p_q;
                    end else if (byte_q == SC_RSHIFT) begin
                        rshift_d = !brk_p_q;
                    end else if (byte_q == SC_CTRL) begin
                        ctrl_d = !brk_p_q;
                    end else begin
                        evt_valid_d = 1'b1;
                        evt_code_d  = byte_q;
                        evt_ext_d   = ext_p_q;
                        evt_break_d = brk_p_q;
                        evt_ascii_d = ext_p_q ? 8'h00 : ascii_w;
                        if (brk_p_q) begin
                            evt_repeat_d = 1'b0;
                            if (held_match) begin
                                held_valid_d = 1'b0;
                            end
                        end else begin
                            evt_repeat_d = held_match;
                            if (!held_match) begin
                                held_code_d  = {ext_p_q, byte_q};
                                held_valid_d = 1'b1;
                                press_cnt_d  = press_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            ext_p_q      <= 1'b0;
            brk_p_q      <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            ctrl_q       <= 1'b0;
            held_valid_q <= 1'b0;
            held_code_q  <= 9'h000;
            press_cnt_q  <= '0;
            ovf_q        <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= 8'h00;
            evt_ext_q    <= 1'b0;
            evt_break_q  <= 1'b0;
            evt_repeat_q <= 1'b0;
            evt_ascii_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            ext_p_q      <= ext_p_d;
            brk_p_q      <= brk_p_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            ctrl_q       <= ctrl_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            press_cnt_q  <= press_cnt_d;
            ovf_q        <= ovf_d;
            evt_valid_q  <= evt_valid_d;
            evt_code_q   <= evt_code_d;
            evt_ext_q    <= evt_ext_d;
            evt_break_q  <= evt_break_d;
            evt_repeat_q <= evt_repeat_d;
            evt_ascii_q  <= evt_ascii_d;
        end
    end

    assign nextdata_n = nextdata_n_q;
    assign evt_valid  = evt_valid_q;
    assign evt_code   = evt_code_q;
    assign evt_ext    = evt_ext_q;
    assign evt_break  = evt_break_q;
    assign evt_repeat = evt_repeat_q;
    assign evt_ascii  = evt_ascii_q;
    assign shift_flag = lshift_q | rshift_q;
    assign ctrl_flag  = ctrl_q;
    assign press_cnt  = press_cnt_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - randomized scoreboard bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic [7:0]       ps2_data = 8'h00;
    logic             ps2_ready = 1'b0;
    logic             ps2_ovf = 1'b0;
    logic             evt_ready = 1'b0;
    logic             nextdata_n, evt_valid, evt_ext, evt_break, evt_repeat;
    logic [7:0]       evt_code, evt_ascii;
    logic             shift_flag, ctrl_flag, ovf_sticky;
    logic [CNT_W-1:0] press_cnt;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_ovf(ps2_ovf), .nextdata_n(nextdata_n), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_break(evt_break), .evt_repeat(evt_repeat), .evt_ascii(evt_ascii),
        .shift_flag(shift_flag), .ctrl_flag(ctrl_flag), .press_cnt(press_cnt),
        .ovf_sticky(ovf_sticky)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] code, input bit ext, input bit brk,
                                       input bit rep, input logic [7:0] ascii);
        return {code, ascii, 5'b0, ext, brk, rep, 8'h00};
    endfunction

    // Reference ASCII table built from character strings.
    function automatic logic [7:0] ref_ascii(input logic [7:0] k, input bit sh);
        string lc = "abcdefghijklmnopqrstuvwxyz";
        string dg = "1234567890";
        string dgs = "!@#$%^&*()";
        string pu = "-=[];',./\\";
        string pus = "_+{}:\"<>?|";
        logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
        logic [7:0] dcodes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                    8'h46, 8'h45};
        logic [7:0] pcodes [10] = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49,
                                    8'h4A, 8'h5D};
        for (int i = 0; i < 26; i++)
            if (k == lcodes[i]) return sh ? (lc[i] - 8'd32) : lc[i];
        for (int i = 0; i < 10; i++)
            if (k == dcodes[i]) return sh ? dgs[i] : dg[i];
        for (int i = 0; i < 10; i++)
            if (k == pcodes[i]) return sh ? pus[i] : pu[i];
        if (k == 8'h0E) return sh ? 8'h7E : 8'h60;
        if (k == 8'h29) return 8'h20;
        if (k == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    // Behavioural model state
    bit          m_ext, m_brk, m_lsh, m_rsh, m_ctrl, m_held_v;
    logic [8:0]  m_held;
    int          m_cnt;
    logic [31:0] exp_q[$];
    logic [7:0]  fifo_q[$];

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_held_v = 0;
        m_held = '0; m_cnt = 0; exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit rep;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (!m_ext && !m_brk && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFF})) begin
        end else begin
            if (b == 8'h12) m_lsh = !m_brk;
            else if (b == 8'h59) m_rsh = !m_brk;
            else if (b == 8'h14) m_ctrl = !m_brk;
            else if (m_brk) begin
                exp_q.push_back(pk(b, m_ext, 1, 0, m_ext ? 8'h00 : ref_ascii(b, m_lsh | m_rsh)));
                if (m_held_v && m_held == {m_ext, b}) m_held_v = 0;
            end else begin
                rep = m_held_v && (m_held == {m_ext, b});
                if (!rep) begin
                    m_held = {m_ext, b}; m_held_v = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end
                exp_q.push_back(pk(b, m_ext, 0, rep, m_ext ? 8'h00 : ref_ascii(b, m_lsh | m_rsh)));
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // FIFO emulation, pop protocol monitor and event consumer
    int          pops = 0, pushed = 0, bad_pop = 0, unstable = 0;
    bit          hold_rdy = 0, prev_low = 0, prev_wait = 0;
    logic [31:0] prev_evt = '0, last_evt = '0, cur;

    always @(negedge clk) begin
        if (clrn && nextdata_n === 1'b0) begin
            if (evt_valid || prev_low || fifo_q.size() == 0) bad_pop++;
            if (fifo_q.size() > 0) model_byte(fifo_q.pop_front());
            pops++;
        end
        prev_low = clrn && (nextdata_n === 1'b0);
        ps2_ready = fifo_q.size() > 0;
        ps2_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        if (clrn && evt_valid === 1'b1) begin
            cur = pk(evt_code, evt_ext, evt_break, evt_repeat, evt_ascii);
            if (prev_wait && cur !== prev_evt) unstable++;
            evt_ready = !hold_rdy && ($urandom_range(0, 99) < 70);
            if (evt_ready) begin
                if (exp_q.size() == 0) check("spurious_evt", 1, 0);
                else check("evt", cur, exp_q.pop_front());
                last_evt = cur;
            end
            prev_wait = !evt_ready;
            prev_evt  = cur;
        end else begin
            evt_ready = !hold_rdy && $urandom_range(0, 1) == 1;
            prev_wait = 0;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        pushed++;
    endtask

    task automatic drain(input string tag);
        int idle = 0;
        for (int c = 0; c < 20000 && idle < 6; c++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && evt_valid === 1'b0 && nextdata_n === 1'b1) idle++;
            else idle = 0;
        end
        check({tag, "_drain"}, idle >= 6, 1);
        check({tag, "_expq_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_shift"}, shift_flag, m_lsh | m_rsh);
        check({tag, "_ctrl"}, ctrl_flag, m_ctrl);
        check({tag, "_cnt"}, press_cnt, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 0;
        repeat (2) @(negedge clk);
        model_reset();
        clrn = 1;
    endtask

    logic [7:0] pool [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h29, 8'h5A, 8'h16, 8'h45, 8'h4E,
                              8'h5D, 8'h75, 8'h6B, 8'h12, 8'h59, 8'h14, 8'hE0, 8'hF0, 8'hF0,
                              8'hE0, 8'hAA, 8'h00, 8'hFA, 8'hFF, 8'hEE, 8'h1C, 8'h1C};

    initial begin
        int base;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_fields", pk(evt_code, evt_ext, evt_break, evt_repeat, evt_ascii), 0);
        check("rst_flags", {shift_flag, ctrl_flag, ovf_sticky}, 0);
        check("rst_cnt", press_cnt, 0);
        clrn = 1;

        // Single make, then release
        pops = 0;
        push(8'h1C);
        drain("t1");
        check("t1_evt", last_evt, pk(8'h1C, 0, 0, 0, 8'h61));
        check("t1_cnt", press_cnt, 1);
        check("t1_pops", pops, 1);
        push(8'hF0); push(8'h1C);
        drain("t1b");

        // Shifted make/break
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
        drain("t2");
        check("t2_brk_evt", last_evt, pk(8'h1C, 0, 1, 0, 8'h41));
        check("t2_shift_off", shift_flag, 0);
        check("t2_cnt", press_cnt, 2);

        // Typematic repeats then release then fresh press
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain("t3");
        check("t3_rep_evt", last_evt, pk(8'h1C, 0, 0, 1, 8'h61));
        check("t3_cnt", press_cnt, 3);
        push(8'hF0); push(8'h1C); push(8'h1C);
        drain("t3b");
        check("t3_fresh_evt", last_evt, pk(8'h1C, 0, 0, 0, 8'h61));
        check("t3_fresh_cnt", press_cnt, 4);
        push(8'hF0); push(8'h1C);
        drain("t3c");

        // Extended key and extended ctrl
        push(8'hE0); push(8'h75);
        drain("t4");
        check("t4_ext_evt", last_evt, pk(8'h75, 1, 0, 0, 8'h00));
        push(8'hE0); push(8'h14);
        drain("t4b");
        check("t4_ctrl_on", ctrl_flag, 1);
        push(8'hE0); push(8'hF0); push(8'h14);
        drain("t4c");
        check("t4_ctrl_off", ctrl_flag, 0);
        push(8'hE0); push(8'hF0); push(8'h75);
        drain("t4d");

        // Backpressure
        hold_rdy = 1;
        push(8'h1C); push(8'h32);
        repeat (20) @(negedge clk);
        check("t5_valid_held", evt_valid, 1);
        check("t5_code_stable", evt_code, 8'h1C);
        check("t5_fifo_not_popped", fifo_q.size(), 1);
        check("t5_no_pop", nextdata_n, 1);
        hold_rdy = 0;
        drain("t5");
        check("t5_second_evt", last_evt, pk(8'h32, 0, 0, 0, 8'h62));
        check_state("t5");

        // Reset clears pending break prefix; overflow is sticky
        push(8'hF0);
        drain("t6");
        do_reset();
        check("t6_cnt_rst", press_cnt, 0);
        push(8'h1C);
        drain("t6b");
        check("t6_make_evt", last_evt, pk(8'h1C, 0, 0, 0, 8'h61));
        @(negedge clk); ps2_ovf = 1;
        @(negedge clk); ps2_ovf = 0;
        repeat (10) @(negedge clk);
        check("t6_ovf_set", ovf_sticky, 1);
        do_reset();
        @(negedge clk);
        check("t6_ovf_clr", ovf_sticky, 0);

        // Randomized byte streams
        for (int r = 0; r < 40; r++) begin
            int n = $urandom_range(5, 25);
            for (int i = 0; i < n; i++) push(pool[$urandom_range(0, 25)]);
            drain("rnd");
            check_state("rnd");
        end

        // Counter wrap
        base = m_cnt;
        push(8'hF0); push(8'h2B);
        for (int i = 0; i < 260; i++) begin
            push(8'h2B); push(8'hF0); push(8'h2B);
        end
        drain("wrap");
        check("wrap_cnt", press_cnt, (base + 260) % 256);
        check_state("wrap");

        check("pop_protocol", bad_pop, 0);
        check("evt_stable", unstable, 0);
        check("pops_total", pops, pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
